// File: rtl/led_sbox_sched.sv
// Issue scheduler for the shared masked S-box lanes of the LED core: serialises one
// SubCells pass into lane batches, gates issue on fresh randomness, aligns state writeback.
module led_sbox_sched #(
   parameter int NUM_NIB  = 16,
   parameter int NUM_LANE = 4,
   parameter int SBOX_LAT = 3,
   parameter int BATCH_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               rand_vld,
   output logic               rand_ack,
   output logic               sbox_en,
   output logic [BATCH_W-1:0] issue_batch,
   output logic               wb_vld,
   output logic [BATCH_W-1:0] wb_batch,
   output logic               busy,
   output logic               done
);

   localparam int                 NUM_BATCH  = NUM_NIB / NUM_LANE;
   localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(NUM_BATCH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [BATCH_W-1:0] cnt, cnt_nxt;

   // Lane F/G stages never stall, so the writeback tracker is a plain delay line.
   logic               vld_p   [SBOX_LAT];
   logic [BATCH_W-1:0] batch_p [SBOX_LAT];

   assign wb_vld   = vld_p[SBOX_LAT-1];
   assign wb_batch = batch_p[SBOX_LAT-1];

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sbox_en     = 1'b0;
      rand_ack    = 1'b0;
      issue_batch = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = ISSUE;
               cnt_nxt   = '0;
            end
         end
         ISSUE: begin
            busy = 1'b1;
            // Randomness is only acknowledged together with an issue; otherwise a bubble.
            if (rand_vld) begin
               sbox_en     = 1'b1;
               rand_ack    = 1'b1;
               issue_batch = cnt;
               cnt_nxt     = cnt + 1'b1;
               if (cnt == LAST_BATCH) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (wb_vld && (wb_batch == LAST_BATCH)) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         for (int i = 0; i < SBOX_LAT; i++) begin
            vld_p[i]   <= 1'b0;
            batch_p[i] <= '0;
         end
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         vld_p[0]   <= sbox_en;
         batch_p[0] <= issue_batch;
         for (int i = 1; i < SBOX_LAT; i++) begin
            vld_p[i]   <= vld_p[i-1];
            batch_p[i] <= batch_p[i-1];
         end
      end
   end

endmodule
